// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and SRAM geometry.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DATA_RD = 2'd2,
    ST_DATA_WR = 2'd3
  } arb_state_t;

  localparam int IMEM_WORDS   = 256;
  localparam int ARB_STREAK_W = 4;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter: fetch and load/store channels.
interface imem_port_arbiter_if #(parameter int ADDR_W = 10) ();
  // Handshake: a requester holds req and its fields stable until the cycle its gnt is high;
  // read data returns with rvalid exactly one cycle after that grant; rdata is valid only with rvalid.
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_stall;
  logic              fetch_rvalid;
  logic [31:0]       fetch_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_be;
  logic              data_gnt;
  logic              data_rvalid;
  logic [31:0]       data_rdata;

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, data_be,
    input  fetch_gnt, fetch_stall, fetch_rvalid, fetch_rdata, data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, data_be,
    output fetch_gnt, fetch_stall, fetch_rvalid, fetch_rdata, data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module arb_streak_counter
  import cpu_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [ARB_STREAK_W-1:0] count,
  output logic                    at_max
);

  localparam logic [ARB_STREAK_W-1:0] MAX_V = ARB_STREAK_W'(MAX);

  assign at_max = (count == MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port SRAM arbiter between fetch and load/store; the fetch-starvation
// limiter is built only when IMEM_ARB_STARVE_GUARD_EN is defined.
module imem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  imem_port_arbiter_if.slave      bus,
  output logic                    mem_en,
  output logic [3:0]              mem_we,
  output logic [ADDR_W-3:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output arb_state_t              state,
  output logic [ARB_STREAK_W-1:0] streak
);

  if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
    $error("MAX_DATA_STREAK must be within 1..15");
  end

  arb_state_t next_state;
  logic       fetch_win;
  logic       data_win;
  logic       at_max;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.fetch_addr[1:0], bus.data_addr[1:0]};

`ifdef IMEM_ARB_STARVE_GUARD_EN
  arb_streak_counter #(.MAX(MAX_DATA_STREAK)) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (bus.data_gnt & bus.fetch_req),
    .clr    (bus.fetch_gnt | ~bus.fetch_req),
    .count  (streak),
    .at_max (at_max)
  );
`else
  assign at_max = 1'b0;
  assign streak = '0;
`endif

  // Data wins a conflict unless fetch has already waited through a full streak.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (bus.data_req && !(bus.fetch_req && at_max)) begin
      data_win = 1'b1;
    end else if (bus.fetch_req) begin
      fetch_win = 1'b1;
    end
  end

  // Grants are forced low throughout reset so nothing reaches the SRAM.
  assign bus.fetch_gnt   = fetch_win & rst_n;
  assign bus.data_gnt    = data_win & rst_n;
  assign bus.fetch_stall = bus.fetch_req & ~bus.fetch_gnt;

  assign mem_en    = bus.fetch_gnt | bus.data_gnt;
  assign mem_we    = (bus.data_gnt && bus.data_we) ? bus.data_be : 4'b0000;
  assign mem_addr  = bus.data_gnt ? bus.data_addr[ADDR_W-1:2] : bus.fetch_addr[ADDR_W-1:2];
  assign mem_wdata = bus.data_wdata;

  always_comb begin
    next_state = ST_IDLE;
    if (bus.data_gnt) begin
      next_state = bus.data_we ? ST_DATA_WR : ST_DATA_RD;
    end else if (bus.fetch_gnt) begin
      next_state = ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign bus.fetch_rvalid = (state == ST_FETCH);
  assign bus.data_rvalid  = (state == ST_DATA_RD);
  assign bus.fetch_rdata  = mem_rdata;
  assign bus.data_rdata   = mem_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter with a behavioural SRAM and response scoreboard.
module tb_imem_port_arbiter;
  import cpu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int MAXS   = 3;
`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  logic                    mem_en;
  logic [3:0]              mem_we;
  logic [ADDR_W-3:0]       mem_addr;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;
  arb_state_t              state;
  logic [ARB_STREAK_W-1:0] streak;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_STREAK(MAXS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state     (state),
    .streak    (streak)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] fetch_q[$];
  logic [31:0] data_q[$];
  logic [31:0] sram[IMEM_WORDS];
  logic [31:0] shadow[IMEM_WORDS];

  function automatic logic [31:0] word_init(int i);
    logic [31:0] v;
    v = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_A5A5;
    if (i == 32'h40) v = 32'h0;
    return v;
  endfunction

  task automatic init_shadow();
    for (int i = 0; i < IMEM_WORDS; i++) shadow[i] = word_init(i);
  endtask

  // SRAM model: reloads its contents while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < IMEM_WORDS; i++) sram[i] <= word_init(i);
    end else if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst_n) begin
      if (bus.fetch_rvalid) begin
        checks++;
        if (fetch_q.size() == 0) begin
          failures++;
          $display("FAIL fetch_rvalid_unexpected got rvalid=1 want rvalid=0 t=%0t", $time);
        end else begin
          exp = fetch_q.pop_front();
          if (bus.fetch_rdata !== exp) begin
            failures++;
            $display("FAIL fetch_rdata got=%h want=%h t=%0t", bus.fetch_rdata, exp, $time);
          end
        end
      end
      if (bus.data_rvalid) begin
        checks++;
        if (data_q.size() == 0) begin
          failures++;
          $display("FAIL data_rvalid_unexpected got rvalid=1 want rvalid=0 t=%0t", $time);
        end else begin
          exp = data_q.pop_front();
          if (bus.data_rdata !== exp) begin
            failures++;
            $display("FAIL data_rdata got=%h want=%h t=%0t", bus.data_rdata, exp, $time);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.data_be    = 4'b0000;
  endtask

  task automatic drive_data(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
    bus.data_be    = be;
  endtask

  task automatic test_reset();
    bus.fetch_req = 1'b1;
    drive_data(1'b1, 10'h004, 32'h1234_5678, 4'b1111);
    #1;
    checks++;
    if ({bus.fetch_gnt, bus.data_gnt, mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_gnt got={fg,dg,en}=%b want=000", {bus.fetch_gnt, bus.data_gnt, mem_en});
    end
    checks++;
    if (mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mem_we got=%b want=0000", mem_we);
    end
    checks++;
    if ({bus.fetch_rvalid, bus.data_rvalid} !== 2'b00 || state !== ST_IDLE || streak !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got rv=%b state=%0d streak=%0d want rv=00 state=0 streak=0",
               {bus.fetch_rvalid, bus.data_rvalid}, state, streak);
    end
    step();
    step();
    drive_idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch_read();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'h310;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'hC4 || bus.fetch_gnt !== 1'b1 || bus.fetch_stall !== 1'b0) begin
      failures++;
      $display("FAIL fetch_grant got en=%b addr=%h gnt=%b stall=%b want en=1 addr=c4 gnt=1 stall=0",
               mem_en, mem_addr, bus.fetch_gnt, bus.fetch_stall);
    end
    fetch_q.push_back(shadow[8'hC4]);
    step();
    drive_idle();
    #1;
    checks++;
    if (bus.fetch_rvalid !== 1'b1 || state !== ST_FETCH) begin
      failures++;
      $display("FAIL fetch_rvalid got rvalid=%b state=%0d want rvalid=1 state=1", bus.fetch_rvalid, state);
    end
    step();
  endtask

  task automatic test_conflict();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'h020;
    drive_data(1'b0, 10'h040, 32'h0, 4'b0000);
    #1;
    checks++;
    if (bus.data_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0 || bus.fetch_stall !== 1'b1 || mem_addr !== 8'h10) begin
      failures++;
      $display("FAIL conflict_data_wins got dg=%b fg=%b stall=%b addr=%h want 1 0 1 10",
               bus.data_gnt, bus.fetch_gnt, bus.fetch_stall, mem_addr);
    end
    data_q.push_back(shadow[8'h10]);
    step();
    bus.data_req = 1'b0;
    #1;
    checks++;
    if (bus.data_rvalid !== 1'b1 || bus.fetch_gnt !== 1'b1 || bus.fetch_stall !== 1'b0 || mem_addr !== 8'h08) begin
      failures++;
      $display("FAIL conflict_fetch_next got drv=%b fg=%b stall=%b addr=%h want 1 1 0 08",
               bus.data_rvalid, bus.fetch_gnt, bus.fetch_stall, mem_addr);
    end
    fetch_q.push_back(shadow[8'h08]);
    step();
    drive_idle();
    step();
  endtask

  task automatic test_store();
    drive_data(1'b1, 10'h100, 32'hDEAD_BEEF, 4'b0011);
    #1;
    checks++;
    if (bus.data_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0011 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 8'h40) begin
      failures++;
      $display("FAIL store_port got gnt=%b en=%b we=%b wd=%h addr=%h want 1 1 0011 deadbeef 40",
               bus.data_gnt, mem_en, mem_we, mem_wdata, mem_addr);
    end
    shadow[8'h40][15:0] = 16'hBEEF;
    step();
    drive_data(1'b0, 10'h100, 32'h0, 4'b1111);
    #1;
    checks++;
    if (bus.data_rvalid !== 1'b0 || state !== ST_DATA_WR || mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL store_no_rvalid got rvalid=%b state=%0d we=%b want 0 3 0000", bus.data_rvalid, state, mem_we);
    end
    data_q.push_back(32'h0000_BEEF);
    step();
    drive_idle();
    #1;
    checks++;
    if (bus.data_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL load_after_store_rvalid got=%b want=1", bus.data_rvalid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 8; i++) begin
      a = (i == 7) ? 10'h3FF : 10'($urandom_range(0, 1023));
      drive_idle();
      if (i % 2 == 0) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        fetch_q.push_back(shadow[a[ADDR_W-1:2]]);
      end else begin
        drive_data(1'b0, a, 32'h0, 4'b0000);
        data_q.push_back(shadow[a[ADDR_W-1:2]]);
      end
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== a[ADDR_W-1:2] || (bus.fetch_gnt ^ bus.data_gnt) !== 1'b1) begin
        failures++;
        $display("FAIL b2b_grant i=%0d got en=%b addr=%h fg=%b dg=%b want en=1 addr=%h one grant",
                 i, mem_en, mem_addr, bus.fetch_gnt, bus.data_gnt, a[ADDR_W-1:2]);
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_streak();
    logic [ADDR_W-1:0] a;
    logic exp_f;
    int fetch_wins = 0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'h080;
    for (int c = 0; c < 20; c++) begin
      a = 10'($urandom_range(0, 1023));
      drive_data(1'b0, a, 32'h0, 4'b0000);
      exp_f = GUARD && (c % (MAXS + 1) == MAXS);
      #1;
      checks++;
      if (bus.fetch_gnt !== exp_f || bus.data_gnt !== !exp_f) begin
        failures++;
        $display("FAIL streak_grant c=%0d got fg=%b dg=%b want fg=%b dg=%b",
                 c, bus.fetch_gnt, bus.data_gnt, exp_f, !exp_f);
      end
      if (bus.fetch_gnt) fetch_wins++;
      if (exp_f) fetch_q.push_back(shadow[8'h20]);
      else       data_q.push_back(shadow[a[ADDR_W-1:2]]);
      step();
    end
    checks++;
    if (fetch_wins != (GUARD ? 5 : 0)) begin
      failures++;
      $display("FAIL streak_fetch_total got=%0d want=%0d", fetch_wins, GUARD ? 5 : 0);
    end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid_access();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'h200;
    #1;
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_grant got=%b want=1", bus.fetch_gnt);
    end
    @(posedge clk);
    #1;
    drive_idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== ST_IDLE || bus.fetch_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got state=%0d rvalid=%b want 0 0", state, bus.fetch_rvalid);
    end
    step();
    rst_n = 1'b1;
    init_shadow();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.fetch_rvalid !== 1'b0 || bus.data_rvalid !== 1'b0 || state !== ST_IDLE) begin
        failures++;
        $display("FAIL midrst_after c=%0d got frv=%b drv=%b state=%0d want 0 0 0",
                 c, bus.fetch_rvalid, bus.data_rvalid, state);
      end
    end
  endtask

  initial begin
    init_shadow();
    drive_idle();
    test_reset();
    test_fetch_read();
    test_conflict();
    test_store();
    test_back_to_back();
    test_streak();
    test_reset_mid_access();
    step();
    checks++;
    if (fetch_q.size() != 0 || data_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got fetch_left=%0d data_left=%0d want 0 0", fetch_q.size(), data_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
